hdr_xfer_port: RTL
==================

# hdr_xfer_port

Parametrised byte-serial host port for the mining core. It collects an IN_BYTES-byte block header from the host one byte per rq/rdy handshake and presents it in parallel to the hash core. It then waits for the core result and returns it OUT_BYTES bytes at a time over the same handshake. Beyond a plain loader, it adds partial reload of only the trailing TAIL_BYTES bytes (nonce update), a synchronised edge-detected rdy, and a transfer timeout with sticky error.

## Interface
Parameters:
- IN_BYTES, 80: header length in bytes, ≥ 1.
- OUT_BYTES, 32: result length in bytes, ≥ 1.
- TAIL_BYTES, 4: bytes reloaded in partial mode, 1..IN_BYTES.
- SYNC_STAGES, 2: rdy synchroniser depth, ≥ 2.
- TIMEOUT, 0: cycles allowed in a request state without a rdy edge; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begin a transfer when idle.
- partial  in  1  sampled with start; 1 = reload tail only.
- rdy  in  1  host strobe, asynchronous to clk; its rising edge is the acceptance event.
- data_in  in  8  header byte; valid when the rdy edge arrives.
- rq  out  1  request: a byte is wanted (load) or data_out is valid (unload).
- data_out  out  8  result byte.
- done  out  1  high during the unload phase.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  sticky timeout flag.
- hdr_out  out  8*IN_BYTES  parallel header; byte 0 sits in the MSBs.
- hdr_valid  out  1  one-cycle pulse when the header is complete.
- res_in  in  8*OUT_BYTES  core result; byte 0 sits in the MSBs.
- res_valid  in  1  core result strobe.

## Operation
- States: IDLE, LOAD_RQ, LOAD_ACK, WAIT_CORE, UNLOAD_RQ, UNLOAD_ACK.
- IDLE:
  - start=1 → LOAD_RQ; err clears.
  - Byte index = 0, or IN_BYTES−TAIL_BYTES when partial=1.
- LOAD_RQ:
  - rq=1.
  - On an accepted rdy edge: write data_in to hdr byte[index], index+1, go to LOAD_ACK.
- LOAD_ACK:
  - rq=0 for exactly one cycle.
  - If index==IN_BYTES: pulse hdr_valid, go to WAIT_CORE. Otherwise return to LOAD_RQ.
- WAIT_CORE:
  - res_valid=1 latches res_in, index=0, go to UNLOAD_RQ.
  - res_valid in any other state is ignored.
- UNLOAD_RQ:
  - rq=1, done=1, data_out = res byte[index].
  - On an accepted edge: index+1, go to UNLOAD_ACK.
- UNLOAD_ACK:
  - rq=0 for one cycle.
  - If index==OUT_BYTES: go to IDLE and drop done. Otherwise return to UNLOAD_RQ.
- Byte order is MSB-first: hdr byte k occupies bits [8*(IN_BYTES−k)−1 -: 8]; the result uses the same mapping.
- The index counter is $clog2(max(IN_BYTES,OUT_BYTES)+1) bits wide and never wraps.
- hdr_out holds its value between transfers. Partial mode preserves bytes 0..IN_BYTES−TAIL_BYTES−1.
- start while busy: ignored.
- rdy edges outside the *_RQ states: discarded; they are never queued.
- Timeout: a counter runs in LOAD_RQ/UNLOAD_RQ and resets on each accepted edge.
  - When it reaches TIMEOUT: go to IDLE with err=1, rq=0, done=0.
  - The header is left partially written; hdr_valid does not pulse.
- Reset mid-transfer: immediate return to IDLE; the header buffer and result register clear to 0.

## Timing
- Reset values: rq=0, done=0, busy=0, err=0, hdr_valid=0, data_out=0, hdr_out=0.
- rdy acceptance: a pin rising edge is accepted SYNC_STAGES+1 clk edges later, provided rdy stays high ≥ SYNC_STAGES+1 cycles. Holding rdy high longer yields a single acceptance.
- rq falls on the edge after acceptance and rises again one cycle later, so rq is low for exactly one cycle between bytes.
- start → rq high: 1 cycle.
- Final load acceptance → hdr_valid: 1 cycle.
- res_valid → rq/done high: 1 cycle.
- data_out is stable from rq rising until the acceptance edge.
- Full load minimum: IN_BYTES*(SYNC_STAGES+3)+1 cycles from start.

## Structure
- Package hdr_xfer_pkg holds:
  - the state enum type;
  - default parameter constants;
  - a function for the index width.
- Sub-module rdy_sync holds the SYNC_STAGES flop chain plus rising-edge detector and outputs a one-cycle pulse.
- The FSM, index counter, timeout counter and byte buffers live in the top module.

## Test plan
- Full load of an 80-byte header with bytes 0x01,0x00,…,0x7C, then res_valid with res_in=0x6FE2…A08C → hdr_out equals the header exactly, hdr_valid pulses once, 32 bytes are returned MSB-first, done falls after the last byte.
- Partial reload with TAIL_BYTES=4, new tail 0xDEADBEEF → only hdr bytes 76..79 change, and exactly 4 rq pulses occur.
- rdy held high for 20 cycles → one byte accepted, and rq shows a one-cycle gap.
- TIMEOUT=16 with no rdy after byte 3 → return to IDLE 16 cycles later with err=1, rq=0 and no hdr_valid; err clears on the next start.
- start pulsed during the load and res_valid pulsed during the load → both ignored, and the transfer completes normally.
- rst_n asserted during unload byte 10 → all outputs at reset values immediately; the next start loads correctly from zeroed buffers.

Source files
------------

// File: rtl/hdr_xfer_pkg.sv
// Shared types and defaults for the byte-serial header/result host port.
package hdr_xfer_pkg;

  localparam int DEF_IN_BYTES    = 80;
  localparam int DEF_OUT_BYTES   = 32;
  localparam int DEF_TAIL_BYTES  = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_RQ,
    ST_LOAD_ACK,
    ST_WAIT_CORE,
    ST_UNLOAD_RQ,
    ST_UNLOAD_ACK
  } state_e;

  // The index must be able to hold the terminal count itself, so it never wraps.
  function automatic int idx_width(input int in_bytes, input int out_bytes);
    int m;
    m = (in_bytes > out_bytes) ? in_bytes : out_bytes;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hdr_xfer_port_if.sv
// Host- and core-facing signal bundle of hdr_xfer_port; master = host/core side, slave = port.
interface hdr_xfer_port_if #(
  parameter int IN_BYTES  = hdr_xfer_pkg::DEF_IN_BYTES,
  parameter int OUT_BYTES = hdr_xfer_pkg::DEF_OUT_BYTES
);

  logic                   start;
  logic                   partial;
  logic                   rdy;
  logic [7:0]             data_in;
  logic                   rq;
  logic [7:0]             data_out;
  logic                   done;
  logic                   busy;
  logic                   err;
  logic [8*IN_BYTES-1:0]  hdr_out;
  logic                   hdr_valid;
  logic [8*OUT_BYTES-1:0] res_in;
  logic                   res_valid;

  modport master (
    output start, partial, rdy, data_in, res_in, res_valid,
    input  rq, data_out, done, busy, err, hdr_out, hdr_valid
  );

  modport slave (
    input  start, partial, rdy, data_in, res_in, res_valid,
    output rq, data_out, done, busy, err, hdr_out, hdr_valid
  );

endinterface

// File: rtl/rdy_sync.sv
// Synchroniser for the asynchronous host strobe, emitting a one-cycle pulse per rising edge.
module rdy_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_pulse = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/hdr_xfer_port.sv
// Byte-serial host port: loads a block header (full or tail-only), hands it to the hash core,
// then streams the core result back MSB-first over the same rq/rdy handshake.
module hdr_xfer_port
  import hdr_xfer_pkg::*;
#(
  parameter int IN_BYTES    = DEF_IN_BYTES,
  parameter int OUT_BYTES   = DEF_OUT_BYTES,
  parameter int TAIL_BYTES  = DEF_TAIL_BYTES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input logic            clk,
  input logic            rst_n,
  hdr_xfer_port_if.slave bus
);

  localparam int IDX_W = idx_width(IN_BYTES, OUT_BYTES);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_IN_END  = IDX_W'(IN_BYTES);
  localparam logic [IDX_W-1:0] IDX_OUT_END = IDX_W'(OUT_BYTES);
  localparam logic [IDX_W-1:0] IDX_TAIL    = IDX_W'(IN_BYTES - TAIL_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                       r_state, w_state_nxt;
  logic [IDX_W-1:0]             r_idx, w_idx_nxt;
  logic [TMO_W-1:0]             r_tmo;
  logic                         r_err, w_err_nxt;
  // Element 0 of a [0:N-1] packed array is the MSB byte, matching the byte-0-in-MSBs wire order.
  logic [0:IN_BYTES-1][7:0]     r_hdr;
  logic [0:OUT_BYTES-1][7:0]    r_res;
  logic                         w_acc, w_in_rq, w_tmo_hit, w_hdr_we, w_res_ld;
  logic [7:0]                   w_res_byte;

  rdy_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rdy_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.rdy),
    .o_pulse (w_acc)
  );

  assign w_in_rq   = (r_state == ST_LOAD_RQ) || (r_state == ST_UNLOAD_RQ);
  assign w_tmo_hit = (TIMEOUT != 0) && w_in_rq && !w_acc && (r_tmo == TMO_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_hdr_we    = 1'b0;
    w_res_ld    = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.start) begin
        w_state_nxt = ST_LOAD_RQ;
        w_err_nxt   = 1'b0;
        w_idx_nxt   = bus.partial ? IDX_TAIL : '0;
      end
      ST_LOAD_RQ: if (w_acc) begin
        w_hdr_we    = 1'b1;
        w_idx_nxt   = r_idx + 1'b1;
        w_state_nxt = ST_LOAD_ACK;
      end else if (w_tmo_hit) begin
        w_state_nxt = ST_IDLE;
        w_err_nxt   = 1'b1;
      end
      ST_LOAD_ACK:  w_state_nxt = (r_idx == IDX_IN_END) ? ST_WAIT_CORE : ST_LOAD_RQ;
      ST_WAIT_CORE: if (bus.res_valid) begin
        w_res_ld    = 1'b1;
        w_idx_nxt   = '0;
        w_state_nxt = ST_UNLOAD_RQ;
      end
      ST_UNLOAD_RQ: if (w_acc) begin
        w_idx_nxt   = r_idx + 1'b1;
        w_state_nxt = ST_UNLOAD_ACK;
      end else if (w_tmo_hit) begin
        w_state_nxt = ST_IDLE;
        w_err_nxt   = 1'b1;
      end
      ST_UNLOAD_ACK: w_state_nxt = (r_idx == IDX_OUT_END) ? ST_IDLE : ST_UNLOAD_RQ;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_res_byte = '0;
    if (r_state == ST_UNLOAD_RQ) begin
      for (int k = 0; k < OUT_BYTES; k++) begin
        if (r_idx == IDX_W'(k)) w_res_byte = r_res[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
      // NOTE: the byte buffers are reset too, so a reset mid-transfer never exposes stale header or result bytes.
      r_hdr   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      if ((TIMEOUT != 0) && w_in_rq && !w_acc && !w_tmo_hit) r_tmo <= r_tmo + 1'b1;
      else                                                    r_tmo <= '0;
      if (w_res_ld) r_res <= bus.res_in;
      for (int k = 0; k < IN_BYTES; k++) begin
        if (w_hdr_we && (r_idx == IDX_W'(k))) r_hdr[k] <= bus.data_in;
      end
    end
  end

  assign bus.rq        = w_in_rq;
  assign bus.done      = (r_state == ST_UNLOAD_RQ) || (r_state == ST_UNLOAD_ACK);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.err       = r_err;
  assign bus.hdr_valid = (r_state == ST_LOAD_ACK) && (r_idx == IDX_IN_END);
  assign bus.hdr_out   = r_hdr;
  assign bus.data_out  = w_res_byte;

endmodule
